// File: rtl/multicycle_ctrl_if.sv
// Control bundle between the multi-cycle sequencer and the rest of the core.
// The master side is the sequencer: it owns requests, PC/IR, selects and strobes.
// The slave side is the datapath/memory environment: it supplies acks, fetched data and ALU results.
interface multicycle_ctrl_if;
    logic        imem_req;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        dmem_req;
    logic        dmem_we;
    logic        dmem_ack;
    logic [31:0] alu_result;
    logic        branch_taken;
    logic [31:0] pc;
    logic [31:0] ir;
    logic        alu_src_a;
    logic        alu_src_b;
    logic [1:0]  wb_sel;
    logic        reg_we;
    logic [2:0]  state;
    logic        trap;
    logic [31:0] instret;

    modport master (
        output imem_req, dmem_req, dmem_we, pc, ir, alu_src_a, alu_src_b,
               wb_sel, reg_we, state, trap, instret,
        input  imem_ack, imem_rdata, dmem_ack, alu_result, branch_taken
    );

    modport slave (
        input  imem_req, dmem_req, dmem_we, pc, ir, alu_src_a, alu_src_b,
               wb_sel, reg_we, state, trap, instret,
        output imem_ack, imem_rdata, dmem_ack, alu_result, branch_taken
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control sequencer: owns PC/IR and steps FETCH/DECODE/EXEC/MEM/WB.
// Latency: 3 (branch), 4 (ALU/jump/store), 5 (load) cycles per instruction at zero wait.
// Backpressure: holds each request until its ack is sampled; each wait cycle adds one cycle.
module multicycle_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    multicycle_ctrl_if.master  bus
);
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      r_state;
    state_t      w_next;
    // Low for the first partial cycle after reset release so the first fetch
    // request starts on a full clock cycle and requests stay low in reset.
    logic        r_run;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic [31:0] r_instret;
    logic        r_trap;

    logic [6:0]  w_op;
    logic [31:0] w_pc_plus4;
    logic        w_legal;
    logic        w_sel_act;
    logic        w_imem_req;
    logic        w_dmem_req;
    logic        w_dmem_we;
    logic        w_reg_we;
    logic        w_alu_src_a;
    logic        w_alu_src_b;
    logic [1:0]  w_wb_sel;

    assign w_op       = r_ir[6:0];
    assign w_pc_plus4 = r_pc + 32'd4;

    // Opcode legality check used in DECODE.
    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: w_legal = 1'b1;
            default:                           w_legal = 1'b0;
        endcase
    end

    // State register plus the post-reset run flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_FETCH;
            r_run   <= 1'b0;
        end else begin
            r_state <= w_next;
            r_run   <= 1'b1;
        end
    end

    // Next-state logic; acks only count while the matching request is high.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FETCH:  w_next = (r_run && bus.imem_ack) ? S_DECODE : S_FETCH;
            S_DECODE: w_next = w_legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (w_op == OP_LOAD || w_op == OP_STORE) w_next = S_MEM;
                else if (w_op == OP_BRANCH)              w_next = S_FETCH;
                else                                     w_next = S_WB;
            end
            S_MEM: begin
                if (bus.dmem_ack) w_next = (w_op == OP_STORE) ? S_FETCH : S_WB;
                else              w_next = S_MEM;
            end
            S_WB:     w_next = S_FETCH;
            S_TRAP:   w_next = S_TRAP;
            default:  w_next = S_FETCH;
        endcase
    end

    // PC, IR, retire counter and sticky trap; PC/instret move on the retiring edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0000_0013;
            r_instret <= 32'd0;
            r_trap    <= 1'b0;
        end else begin
            case (r_state)
                S_FETCH: begin
                    if (r_run && bus.imem_ack) r_ir <= bus.imem_rdata;
                end
                S_DECODE: begin
                    if (!w_legal) r_trap <= 1'b1;
                end
                S_EXEC: begin
                    if (w_op == OP_BRANCH) begin
                        r_pc      <= bus.branch_taken ? bus.alu_result : w_pc_plus4;
                        r_instret <= r_instret + 32'd1;
                    end
                end
                S_MEM: begin
                    if (bus.dmem_ack && w_op == OP_STORE) begin
                        r_pc      <= w_pc_plus4;
                        r_instret <= r_instret + 32'd1;
                    end
                end
                S_WB: begin
                    if (w_op == OP_JAL)       r_pc <= bus.alu_result;
                    else if (w_op == OP_JALR) r_pc <= bus.alu_result & ~32'h1;
                    else                      r_pc <= w_pc_plus4;
                    r_instret <= r_instret + 32'd1;
                end
                default: ;
            endcase
        end
    end

    // Moore outputs: strobes from state, selects from IR while in EXEC/MEM/WB.
    always_comb begin
        w_sel_act   = (r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB);
        w_imem_req  = (r_state == S_FETCH) && r_run;
        w_dmem_req  = (r_state == S_MEM);
        w_dmem_we   = (r_state == S_MEM) && (w_op == OP_STORE);
        w_reg_we    = (r_state == S_WB);
        w_alu_src_a = w_sel_act && (w_op == OP_AUIPC || w_op == OP_JAL || w_op == OP_BRANCH);
        w_alu_src_b = w_sel_act && (w_op != OP_R);
        w_wb_sel    = 2'b00;
        if (w_sel_act) begin
            if (w_op == OP_LOAD)                         w_wb_sel = 2'b01;
            else if (w_op == OP_JAL || w_op == OP_JALR)  w_wb_sel = 2'b10;
            else if (w_op == OP_LUI)                     w_wb_sel = 2'b11;
            else                                         w_wb_sel = 2'b00;
        end
    end

    assign bus.imem_req  = w_imem_req;
    assign bus.dmem_req  = w_dmem_req;
    assign bus.dmem_we   = w_dmem_we;
    assign bus.reg_we    = w_reg_we;
    assign bus.alu_src_a = w_alu_src_a;
    assign bus.alu_src_b = w_alu_src_b;
    assign bus.wb_sel    = w_wb_sel;
    assign bus.pc        = r_pc;
    assign bus.ir        = r_ir;
    assign bus.state     = r_state;
    assign bus.trap      = r_trap;
    assign bus.instret   = r_instret;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: stimulus pushes the expected per-instruction
// record, a negedge monitor accumulates observed behaviour and pops/compares on each retire.
module tb_multicycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multicycle_ctrl_if bus();

    multicycle_ctrl #(.RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instret;
        int          cyc;
        int          rwe;
        int          dcyc;
        logic [1:0]  wsel;
        logic        sa;
        logic        sb;
        logic        dwe;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_cur;
    int   checks = 0;
    int   errors = 0;
    logic [31:0] exp_ret = 32'd0;

    int          m_cyc, m_rwe, m_dcyc;
    logic [1:0]  m_wsel;
    logic        m_sa, m_sb, m_dwe;
    logic [31:0] m_prev_ret;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, expv);
        end
    endtask

    task automatic m_clear();
        m_cyc = 0; m_rwe = 0; m_dcyc = 0;
        m_wsel = 2'b00; m_sa = 1'b0; m_sb = 1'b0; m_dwe = 1'b0;
    endtask

    // Monitor: sample away from the rising edge, compare a record on each retirement.
    always @(negedge clk) begin
        if (!rst_n) begin
            m_clear();
            m_prev_ret = 32'd0;
        end else begin
            if (bus.instret !== m_prev_ret) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_retire", bus.instret, m_prev_ret);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("pc",        bus.pc,        e_cur.pc);
                    chk("instret",   bus.instret,   e_cur.instret);
                    chk("cycles",    32'(m_cyc),    32'(e_cur.cyc));
                    chk("reg_we_n",  32'(m_rwe),    32'(e_cur.rwe));
                    chk("wb_sel",    32'(m_wsel),   32'(e_cur.wsel));
                    chk("alu_src_a", 32'(m_sa),     32'(e_cur.sa));
                    chk("alu_src_b", 32'(m_sb),     32'(e_cur.sb));
                    chk("dmem_cyc",  32'(m_dcyc),   32'(e_cur.dcyc));
                    chk("dmem_we",   32'(m_dwe),    32'(e_cur.dwe));
                end
                m_prev_ret = bus.instret;
                m_clear();
            end
            if (bus.state != 3'd0 || bus.imem_req) m_cyc++;
            if (bus.reg_we) begin
                m_rwe++;
                m_wsel = bus.wb_sel;
            end
            if (bus.dmem_req) begin
                m_dcyc++;
                m_dwe = m_dwe | bus.dmem_we;
            end
            if (bus.state == 3'd2) begin
                m_sa = bus.alu_src_a;
                m_sb = bus.alu_src_b;
            end
        end
    end

    task automatic wait_imem_req();
        int n = 0;
        while (!bus.imem_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.imem_req) chk("imem_req_timeout", 32'(bus.imem_req), 32'd1);
    endtask

    task automatic wait_dmem_req();
        int n = 0;
        while (!bus.dmem_req && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!bus.dmem_req) chk("dmem_req_timeout", 32'(bus.dmem_req), 32'd1);
    endtask

    task automatic fetch(input logic [31:0] instr, input int iw);
        wait_imem_req();
        repeat (iw) begin
            @(posedge clk); #1;
        end
        bus.imem_ack   = 1'b1;
        bus.imem_rdata = instr;
        @(posedge clk); #1;
        bus.imem_ack   = 1'b0;
    endtask

    // One instruction: push expected record, then play memory for it.
    task automatic run_instr(input logic [31:0] instr, input int iw, input int dw,
                             input logic [31:0] alu, input logic tk,
                             input logic [31:0] epc, input int ecyc, input int erwe,
                             input logic [1:0] ews, input logic esa, input logic esb,
                             input int edcyc, input logic edwe);
        exp_t e;
        int n;
        exp_ret = exp_ret + 32'd1;
        e.pc = epc; e.instret = exp_ret; e.cyc = ecyc; e.rwe = erwe; e.dcyc = edcyc;
        e.wsel = ews; e.sa = esa; e.sb = esb; e.dwe = edwe;
        exp_q.push_back(e);
        bus.alu_result   = alu;
        bus.branch_taken = tk;
        fetch(instr, iw);
        if (edcyc > 0) begin
            wait_dmem_req();
            repeat (dw) begin
                @(posedge clk); #1;
            end
            bus.dmem_ack = 1'b1;
            @(posedge clk); #1;
            bus.dmem_ack = 1'b0;
        end
        n = 0;
        while (bus.instret !== exp_ret && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.instret !== exp_ret) chk("retire_timeout", bus.instret, exp_ret);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_state"},   32'(bus.state),    32'd0);
        chk({tag, "_pc"},      bus.pc,            32'h0000_0000);
        chk({tag, "_ir"},      bus.ir,            32'h0000_0013);
        chk({tag, "_instret"}, bus.instret,       32'd0);
        chk({tag, "_trap"},    32'(bus.trap),     32'd0);
        chk({tag, "_imemreq"}, 32'(bus.imem_req), 32'd0);
        chk({tag, "_dmemreq"}, 32'(bus.dmem_req), 32'd0);
        chk({tag, "_reg_we"},  32'(bus.reg_we),   32'd0);
        chk({tag, "_wb_sel"},  32'(bus.wb_sel),   32'd0);
    endtask

    initial begin
        int n_ireq, n_dreq, n_rwe;
        bus.imem_ack = 1'b0; bus.imem_rdata = 32'h0; bus.dmem_ack = 1'b0;
        bus.alu_result = 32'h0; bus.branch_taken = 1'b0;
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_vals("rst0");
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_imem_req", 32'(bus.imem_req), 32'd1);

        //        instr          iw dw alu           tk  pc            cyc rwe ws     sa    sb    dcyc dwe
        run_instr(32'h00500093, 0, 0, 32'h0,       0, 32'h0000_0004, 4, 1, 2'b00, 1'b0, 1'b1, 0, 1'b0); // ADDI
        run_instr(32'h0000A103, 1, 3, 32'h0,       0, 32'h0000_0008, 9, 1, 2'b01, 1'b0, 1'b1, 4, 1'b0); // LW
        run_instr(32'h0020A223, 0, 0, 32'h0,       0, 32'h0000_000C, 4, 0, 2'b00, 1'b0, 1'b1, 1, 1'b1); // SW
        run_instr(32'h00000063, 0, 0, 32'h100,     1, 32'h0000_0100, 3, 0, 2'b00, 1'b1, 1'b1, 0, 1'b0); // BEQ taken
        run_instr(32'h00000063, 0, 0, 32'h500,     0, 32'h0000_0104, 3, 0, 2'b00, 1'b1, 1'b1, 0, 1'b0); // BEQ not taken
        run_instr(32'h002081B3, 2, 0, 32'h999,     0, 32'h0000_0108, 6, 1, 2'b00, 1'b0, 1'b0, 0, 1'b0); // ADD
        run_instr(32'h000280E7, 0, 0, 32'h201,     0, 32'h0000_0200, 4, 1, 2'b10, 1'b0, 1'b1, 0, 1'b0); // JALR
        run_instr(32'h008000EF, 0, 0, 32'h300,     0, 32'h0000_0300, 4, 1, 2'b10, 1'b1, 1'b1, 0, 1'b0); // JAL
        run_instr(32'h12345037, 0, 0, 32'h0,       0, 32'h0000_0304, 4, 1, 2'b11, 1'b0, 1'b1, 0, 1'b0); // LUI
        run_instr(32'h00001017, 0, 0, 32'h0,       0, 32'h0000_0308, 4, 1, 2'b00, 1'b1, 1'b1, 0, 1'b0); // AUIPC
        run_instr(32'h008000EF, 0, 0, 32'hFFFFFFFC,0, 32'hFFFF_FFFC, 4, 1, 2'b10, 1'b1, 1'b1, 0, 1'b0); // JAL to top
        run_instr(32'h00500093, 0, 0, 32'h0,       0, 32'h0000_0000, 4, 1, 2'b00, 1'b0, 1'b1, 0, 1'b0); // ADDI wraps
        run_instr(32'h00500093, 0, 0, 32'h0,       0, 32'h0000_0004, 4, 1, 2'b00, 1'b0, 1'b1, 0, 1'b0); // ADDI

        // Illegal opcode: trap is terminal, ack without request is ignored.
        fetch(32'hFFFF_FFFF, 0);
        begin
            int n = 0;
            while (bus.state != 3'd5 && n < 20) begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk("trap_state", 32'(bus.state), 32'd5);
        chk("trap_flag",  32'(bus.trap),  32'd1);
        n_ireq = 0; n_dreq = 0; n_rwe = 0;
        bus.imem_ack = 1'b1;
        bus.imem_rdata = 32'h00500093;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.imem_req) n_ireq++;
            if (bus.dmem_req) n_dreq++;
            if (bus.reg_we)   n_rwe++;
        end
        bus.imem_ack = 1'b0;
        chk("trap_imem_req_n", 32'(n_ireq), 32'd0);
        chk("trap_dmem_req_n", 32'(n_dreq), 32'd0);
        chk("trap_reg_we_n",   32'(n_rwe),  32'd0);
        chk("trap_pc",         bus.pc,      32'h0000_0004);
        chk("trap_ir",         bus.ir,      32'hFFFF_FFFF);
        chk("trap_instret",    bus.instret, 32'd13);
        chk("trap_sticky",     32'(bus.trap), 32'd1);

        rst_n = 1'b0;
        #1;
        check_reset_vals("rst1");
        @(posedge clk); #1;
        rst_n = 1'b1;
        exp_ret = 32'd0;

        // Reset asserted mid-MEM: request must drop without a clock edge.
        fetch(32'h0000A103, 0);
        wait_dmem_req();
        @(posedge clk); #3;
        chk("mid_mem_dmem_req", 32'(bus.dmem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_drop_dmem_req", 32'(bus.dmem_req), 32'd0);
        chk("async_state",         32'(bus.state),    32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        chk("post_rst_instret", bus.instret, 32'd0);
        chk("post_rst_ir",      bus.ir,      32'h0000_0013);
        chk("post_rst_pc",      bus.pc,      32'h0000_0000);
        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
